pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush, and saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 128,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [31:0]       stall_cnt_q,  stall_cnt_d;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic emit;
    logic main_free;

    // With SKID=0 the stage can take a new entry in the same cycle the old one leaves.
    assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);

    assign accept    = in_valid && in_ready;
    assign emit      = main_valid_q && out_ready;
    assign main_free = !main_valid_q || emit;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!main_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_NOP;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_NOP;
            skid_data_d  = '0;
        end else if (main_free) begin
            // The skid entry is older than anything on the input, so it refills main first.
            if ((SKID != 0) && skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_NOP;
            end
        end else if ((SKID != 0) && accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_NOP;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_NOP;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: skid variant (dut) and single-entry variant (dut0)
// share the same input stimulus; each task checks one scenario against hand-computed values.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [CW-1:0] NOP1 = 16'h0041;
    localparam logic [CW-1:0] NOP0 = 16'h0000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl1;
    logic [DW-1:0] out_data1;
    logic [31:0]   stall_cnt1, bubble_cnt1;

    logic          in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl0;
    logic [DW-1:0] out_data0;
    logic [31:0]   stall_cnt0, bubble_cnt0;

    int total;
    int bad;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP1), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP0), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ctrl_of(input int i);
        return CW'(16'h0100 + i);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return 32'hD000_0000 + DW'(i);
    endfunction

    // Every action happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i);
        in_valid = 1'b1;
        in_ctrl  = ctrl_of(i);
        in_data  = data_of(i);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid1, out_ctrl1, out_data1} !== {1'b0, NOP1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL reset_out: got v=%b c=%h d=%h want v=0 c=%h d=0", out_valid1, out_ctrl1, out_data1, NOP1);
        end
        total++;
        if ({stall_cnt1, bubble_cnt1} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_cnt: got stall=%0d bubble=%0d want 0 0", stall_cnt1, bubble_cnt1);
        end
        total++;
        if (in_ready1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready1);
        end
    endtask

    task automatic test_bubble();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if ({out_valid1, out_ctrl1} !== {1'b0, NOP1}) begin
                bad++;
                $display("[TB] FAIL bubble_ctrl[%0d]: got v=%b c=%h want v=0 c=%h", i, out_valid1, out_ctrl1, NOP1);
            end
        end
        total++;
        if (bubble_cnt1 !== 32'd5) begin
            bad++;
            $display("[TB] FAIL bubble_cnt: got %0d want 5", bubble_cnt1);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(i);
            tick();
            total++;
            if ({out_valid1, out_ctrl1, out_data1, in_ready1} !== {1'b1, ctrl_of(i), data_of(i), 1'b1}) begin
                bad++;
                $display("[TB] FAIL stream[%0d]: got v=%b c=%h d=%h r=%b want v=1 c=%h d=%h r=1",
                         i, out_valid1, out_ctrl1, out_data1, in_ready1, ctrl_of(i), data_of(i));
            end
        end
        in_valid = 1'b0;
        total++;
        if (stall_cnt1 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL stream_stall: got %0d want 0", stall_cnt1);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d [3];
        logic [2:0]    exp_r;
        do_reset();
        offer(0);
        tick();
        offer(1);
        tick();
        offer(2);
        tick();
        total++;
        if ({out_data1, in_ready1} !== {data_of(0), 1'b0}) begin
            bad++;
            $display("[TB] FAIL bp_hold: got d=%h r=%b want d=%h r=0", out_data1, in_ready1, data_of(0));
        end
        tick();
        total++;
        if ({out_valid1, out_data1, in_ready1, stall_cnt1} !== {1'b1, data_of(0), 1'b0, 32'd3}) begin
            bad++;
            $display("[TB] FAIL bp_stall: got v=%b d=%h r=%b stall=%0d want v=1 d=%h r=0 stall=3",
                     out_valid1, out_data1, in_ready1, stall_cnt1, data_of(0));
        end
        out_ready = 1'b1;
        exp_d[0] = data_of(1); exp_d[1] = data_of(2); exp_d[2] = data_of(2);
        exp_r = 3'b011;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({out_valid1, out_data1, in_ready1} !== {1'b1, exp_d[k], exp_r[k]}) begin
                bad++;
                $display("[TB] FAIL bp_drain[%0d]: got v=%b d=%h r=%b want v=1 d=%h r=%b",
                         k, out_valid1, out_data1, in_ready1, exp_d[k], exp_r[k]);
            end
            if (k == 0) in_valid = 1'b1;
            else in_valid = 1'b0;
        end
        tick();
        total++;
        if ({out_valid1, out_ctrl1, out_data1, stall_cnt1} !== {1'b0, NOP1, data_of(2), 32'd3}) begin
            bad++;
            $display("[TB] FAIL bp_empty: got v=%b c=%h d=%h stall=%0d want v=0 c=%h d=%h stall=3",
                     out_valid1, out_ctrl1, out_data1, stall_cnt1, NOP1, data_of(2));
        end
    endtask

    task automatic test_flush();
        do_reset();
        offer(10);
        tick();
        offer(11);
        tick();
        total++;
        if ({out_data1, in_ready1} !== {data_of(10), 1'b0}) begin
            bad++;
            $display("[TB] FAIL flush_setup: got d=%h r=%b want d=%h r=0", out_data1, in_ready1, data_of(10));
        end
        offer(12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if ({out_valid1, out_ctrl1, out_data1, in_ready1} !== {1'b0, NOP1, 32'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL flush_clear: got v=%b c=%h d=%h r=%b want v=0 c=%h d=0 r=1",
                     out_valid1, out_ctrl1, out_data1, in_ready1, NOP1);
        end
        total++;
        if (stall_cnt1 !== 32'd2) begin
            bad++;
            $display("[TB] FAIL flush_stall: got %0d want 2", stall_cnt1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (out_valid1 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flush_gone[%0d]: got v=%b d=%h want v=0", k, out_valid1, out_data1);
            end
        end
        offer(13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({out_valid1, out_data1} !== {1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL flush_accept: got v=%b d=%h want v=0 d=0", out_valid1, out_data1);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        offer(20);
        tick();
        offer(21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if ({out_valid1, out_data1, bubble_cnt1} !== {1'b0, 32'h0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL rst_mid: got v=%b d=%h bubble=%0d want v=0 d=0 bubble=0", out_valid1, out_data1, bubble_cnt1);
        end
        tick();
        total++;
        if ({out_valid1, bubble_cnt1} !== {1'b0, 32'd1}) begin
            bad++;
            $display("[TB] FAIL rst_mid_after: got v=%b bubble=%0d want v=0 bubble=1", out_valid1, bubble_cnt1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        offer(30);
        tick();
        in_valid = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        tick();
        total++;
        if (stall_cnt1 !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL sat_first: got %h want ffffffff", stall_cnt1);
        end
        tick();
        tick();
        total++;
        if ({stall_cnt1, out_data1} !== {32'hFFFF_FFFF, data_of(30)}) begin
            bad++;
            $display("[TB] FAIL sat_hold: got stall=%h d=%h want stall=ffffffff d=%h", stall_cnt1, out_data1, data_of(30));
        end
    endtask

    task automatic test_skid0();
        do_reset();
        offer(40);
        #1;
        total++;
        if (in_ready0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL s0_empty_ready: got %b want 1", in_ready0);
        end
        tick();
        offer(41);
        #1;
        total++;
        if ({out_valid0, out_data0, in_ready0} !== {1'b1, data_of(40), 1'b0}) begin
            bad++;
            $display("[TB] FAIL s0_full_block: got v=%b d=%h r=%b want v=1 d=%h r=0", out_valid0, out_data0, in_ready0, data_of(40));
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL s0_comb_ready: got %b want 1", in_ready0);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid0, out_ctrl0, out_data0} !== {1'b1, ctrl_of(41), data_of(41)}) begin
            bad++;
            $display("[TB] FAIL s0_load: got v=%b c=%h d=%h want v=1 c=%h d=%h", out_valid0, out_ctrl0, out_data0, ctrl_of(41), data_of(41));
        end
        tick();
        total++;
        if ({out_valid0, out_ctrl0} !== {1'b0, NOP0}) begin
            bad++;
            $display("[TB] FAIL s0_drain: got v=%b c=%h want v=0 c=%h", out_valid0, out_ctrl0, NOP0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #2;
        test_reset();
        test_bubble();
        test_stream();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_saturation();
        test_skid0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
